// File: rtl/ddr_cmd_pkg.sv
// Shared definitions for the DDR command decoder: pin encodings,
// power-mode enumeration, command vector layout and error counter helpers.
package ddr_cmd_pkg;

   // {ras_n, cas_n, we_n} encodings seen with cs_n=0, act_n=1
   localparam logic [2:0] ENC_MRS = 3'b000;
   localparam logic [2:0] ENC_REF = 3'b001;
   localparam logic [2:0] ENC_PRE = 3'b010;
   localparam logic [2:0] ENC_BST = 3'b011;
   localparam logic [2:0] ENC_WR  = 3'b100;
   localparam logic [2:0] ENC_RD  = 3'b101;
   localparam logic [2:0] ENC_RSV = 3'b110;
   localparam logic [2:0] ENC_NOP = 3'b111;

   // Error counter width and saturation value
   localparam int                  ERR_CT_W   = 8;
   localparam logic [ERR_CT_W-1:0] ERR_CT_MAX = 8'd255;

   // Power modes, numbered as reported on pwr_state
   typedef enum logic [1:0] {
      PWR_ACTIVE = 2'd0,
      PWR_PDN    = 2'd1,
      PWR_SREF   = 2'd2,
      PWR_DPDN   = 2'd3
   } pwr_state_e;

   // Bit positions of the one-hot command vector; NOP also covers deselect
   localparam int CMD_ACT = 0;
   localparam int CMD_MRR = 1;
   localparam int CMD_MRW = 2;
   localparam int CMD_REF = 3;
   localparam int CMD_PR  = 4;
   localparam int CMD_PRA = 5;
   localparam int CMD_BST = 6;
   localparam int CMD_WR  = 7;
   localparam int CMD_WRA = 8;
   localparam int CMD_RD  = 9;
   localparam int CMD_RDA = 10;
   localparam int CMD_RSV = 11;
   localparam int CMD_NOP = 12;
   localparam int CMD_W   = 13;

   typedef logic [CMD_W-1:0] cmd_vec_t;

   // Registered pulse outputs toward the timing FSM
   typedef struct packed {
      logic act;
      logic bst;
      logic cfg;
      logic ckeh;
      logic ckel;
      logic dpd;
      logic dpdx;
      logic mrr;
      logic mrw;
      logic pd;
      logic pdx;
      logic pr;
      logic pra;
      logic rd;
      logic rda;
      logic refresh;
      logic srf;
      logic wr;
      logic wra;
   } pulse_t;

   // Saturating increment: the counter sticks at its maximum
   function automatic logic [ERR_CT_W-1:0] sat_inc(input logic [ERR_CT_W-1:0] v);
      if (v == ERR_CT_MAX) begin
         return v;
      end else begin
         return v + 8'd1;
      end
   endfunction

endpackage

// File: rtl/ddr_cmd_decoder_if.sv
// Command pins in, decoded pulses and status out.
interface ddr_cmd_decoder_if;
   import ddr_cmd_pkg::*;

   logic cke, cs_n, act_n, ras_n, cas_n, we_n;
   logic a10, a12, a13;

   logic ACT, BST, CFG, CKEH, CKEL, DPD, DPDX, MRR, MRW, PD, PDX;
   logic PR, PRA, RD, RDA, REF, SRF, WR, WRA;
   logic [1:0]          pwr_state;
   logic [ERR_CT_W-1:0] err_ct;

   modport master (
      output cke, cs_n, act_n, ras_n, cas_n, we_n, a10, a12, a13,
      input  ACT, BST, CFG, CKEH, CKEL, DPD, DPDX, MRR, MRW, PD, PDX,
      input  PR, PRA, RD, RDA, REF, SRF, WR, WRA, pwr_state, err_ct
   );

   modport slave (
      input  cke, cs_n, act_n, ras_n, cas_n, we_n, a10, a12, a13,
      output ACT, BST, CFG, CKEH, CKEL, DPD, DPDX, MRR, MRW, PD, PDX,
      output PR, PRA, RD, RDA, REF, SRF, WR, WRA, pwr_state, err_ct
   );

endinterface

// File: rtl/ddr_cmd_table.sv
// Pure pin-to-command lookup. Ignores cke; power-state qualification
// happens in the decoder. Exactly one bit of cmd_o is set per input.
module ddr_cmd_table
   import ddr_cmd_pkg::*;
(
   input  logic     cs_n_i,
   input  logic     act_n_i,
   input  logic     ras_n_i,
   input  logic     cas_n_i,
   input  logic     we_n_i,
   input  logic     a10_i,
   input  logic     a12_i,
   input  logic     a13_i,
   output cmd_vec_t cmd_o,
   output logic     cfg_o
);

   // Decode pins to a one-hot command; cfg_o qualifies an MRW
   always_comb begin
      cmd_o = '0;
      cfg_o = 1'b0;
      if (cs_n_i) begin
         cmd_o[CMD_NOP] = 1'b1;
      end else if (!act_n_i) begin
         cmd_o[CMD_ACT] = 1'b1;
      end else begin
         case ({ras_n_i, cas_n_i, we_n_i})
            ENC_MRS: begin
               if (a13_i) begin
                  cmd_o[CMD_MRR] = 1'b1;
               end else begin
                  cmd_o[CMD_MRW] = 1'b1;
                  cfg_o          = a12_i;
               end
            end
            ENC_REF: cmd_o[CMD_REF] = 1'b1;
            ENC_PRE: begin
               if (a10_i) begin
                  cmd_o[CMD_PRA] = 1'b1;
               end else begin
                  cmd_o[CMD_PR] = 1'b1;
               end
            end
            ENC_BST: cmd_o[CMD_BST] = 1'b1;
            ENC_WR: begin
               if (a10_i) begin
                  cmd_o[CMD_WRA] = 1'b1;
               end else begin
                  cmd_o[CMD_WR] = 1'b1;
               end
            end
            ENC_RD: begin
               if (a10_i) begin
                  cmd_o[CMD_RDA] = 1'b1;
               end else begin
                  cmd_o[CMD_RD] = 1'b1;
               end
            end
            ENC_RSV: cmd_o[CMD_RSV] = 1'b1;
            ENC_NOP: cmd_o[CMD_NOP] = 1'b1;
            default: cmd_o[CMD_NOP] = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/ddr_cmd_decoder.sv
// DDR command decoder: qualifies table commands with cke edges and the
// power-mode FSM, and registers one-cycle pulses plus status outputs.
module ddr_cmd_decoder
   import ddr_cmd_pkg::*;
(
   input logic              clk,
   input logic              rst,
   ddr_cmd_decoder_if.slave bus
);

   cmd_vec_t            cmd_s;
   logic                cfg_s;
   logic                cke_fall_s, cke_rise_s, err_inc_s;
   logic                cke_q;
   pwr_state_e          pwr_q, pwr_d;
   pulse_t              pulse_q, pulse_d;
   logic [ERR_CT_W-1:0] err_q, err_d;

   ddr_cmd_table u_table (
      .cs_n_i  (bus.cs_n),
      .act_n_i (bus.act_n),
      .ras_n_i (bus.ras_n),
      .cas_n_i (bus.cas_n),
      .we_n_i  (bus.we_n),
      .a10_i   (bus.a10),
      .a12_i   (bus.a12),
      .a13_i   (bus.a13),
      .cmd_o   (cmd_s),
      .cfg_o   (cfg_s)
   );

   assign cke_fall_s = cke_q & ~bus.cke;
   assign cke_rise_s = ~cke_q & bus.cke;

   // Next mode, pulses and error event from the current mode and pins
   always_comb begin
      pulse_d   = '0;
      pwr_d     = pwr_q;
      err_inc_s = 1'b0;
      case (pwr_q)
         PWR_ACTIVE: begin
            if (cke_fall_s) begin
               // Power-down entry; the same-cycle command picks the mode
               pulse_d.ckel = 1'b1;
               if (cmd_s[CMD_REF]) begin
                  pulse_d.srf = 1'b1;
                  pwr_d       = PWR_SREF;
               end else if (cmd_s[CMD_BST]) begin
                  pulse_d.dpd = 1'b1;
                  pwr_d       = PWR_DPDN;
               end else begin
                  pulse_d.pd = 1'b1;
                  pwr_d      = PWR_PDN;
                  err_inc_s  = ~cmd_s[CMD_NOP];
               end
            end else if (cke_rise_s) begin
               // Glitch while already active: announce it, keep the mode
               pulse_d.ckeh = 1'b1;
            end else if (bus.cke) begin
               pulse_d.act     = cmd_s[CMD_ACT];
               pulse_d.mrr     = cmd_s[CMD_MRR];
               pulse_d.mrw     = cmd_s[CMD_MRW];
               pulse_d.cfg     = cmd_s[CMD_MRW] & cfg_s;
               pulse_d.refresh = cmd_s[CMD_REF];
               pulse_d.pr      = cmd_s[CMD_PR];
               pulse_d.pra     = cmd_s[CMD_PRA];
               pulse_d.bst     = cmd_s[CMD_BST];
               pulse_d.wr      = cmd_s[CMD_WR];
               pulse_d.wra     = cmd_s[CMD_WRA];
               pulse_d.rd      = cmd_s[CMD_RD];
               pulse_d.rda     = cmd_s[CMD_RDA];
               err_inc_s       = cmd_s[CMD_RSV];
            end else begin
               pulse_d = '0;
            end
         end
         PWR_PDN, PWR_SREF, PWR_DPDN: begin
            if (cke_rise_s) begin
               pulse_d.ckeh = 1'b1;
               pulse_d.pdx  = (pwr_q == PWR_PDN);
               pulse_d.dpdx = (pwr_q == PWR_DPDN);
               pwr_d        = PWR_ACTIVE;
            end else if (cke_fall_s) begin
               // Cannot happen with cke already low; count it, pulse nothing
               err_inc_s = 1'b1;
            end else if (!bus.cke && !cmd_s[CMD_NOP]) begin
               err_inc_s = 1'b1;
            end else begin
               err_inc_s = 1'b0;
            end
         end
         default: pwr_d = PWR_ACTIVE;
      endcase
   end

   // Saturating error counter next value
   always_comb begin
      if (err_inc_s) begin
         err_d = sat_inc(err_q);
      end else begin
         err_d = err_q;
      end
   end

   // State, cke history and output registers; reset forces cke_q high
   always_ff @(posedge clk) begin
      if (rst) begin
         pulse_q <= '0;
         pwr_q   <= PWR_ACTIVE;
         err_q   <= '0;
         cke_q   <= 1'b1;
      end else begin
         pulse_q <= pulse_d;
         pwr_q   <= pwr_d;
         err_q   <= err_d;
         cke_q   <= bus.cke;
      end
   end

   assign bus.ACT       = pulse_q.act;
   assign bus.BST       = pulse_q.bst;
   assign bus.CFG       = pulse_q.cfg;
   assign bus.CKEH      = pulse_q.ckeh;
   assign bus.CKEL      = pulse_q.ckel;
   assign bus.DPD       = pulse_q.dpd;
   assign bus.DPDX      = pulse_q.dpdx;
   assign bus.MRR       = pulse_q.mrr;
   assign bus.MRW       = pulse_q.mrw;
   assign bus.PD        = pulse_q.pd;
   assign bus.PDX       = pulse_q.pdx;
   assign bus.PR        = pulse_q.pr;
   assign bus.PRA       = pulse_q.pra;
   assign bus.RD        = pulse_q.rd;
   assign bus.RDA       = pulse_q.rda;
   assign bus.REF       = pulse_q.refresh;
   assign bus.SRF       = pulse_q.srf;
   assign bus.WR        = pulse_q.wr;
   assign bus.WRA       = pulse_q.wra;
   assign bus.pwr_state = pwr_q;
   assign bus.err_ct    = err_q;

endmodule

// File: tb/tb_ddr_cmd_decoder.sv
// Scoreboard bench for ddr_cmd_decoder: directed scenarios then random pins,
// each clock edge predicted by a string-level command/mode model.
module tb_ddr_cmd_decoder;

   // Output vector bit positions
   localparam int P_ACT  = 18, P_BST = 17, P_CFG = 16, P_CKEH = 15, P_CKEL = 14;
   localparam int P_DPD  = 13, P_DPDX = 12, P_MRR = 11, P_MRW = 10, P_PD = 9;
   localparam int P_PDX  = 8,  P_PR = 7, P_PRA = 6, P_RD = 5, P_RDA = 4;
   localparam int P_REF  = 3,  P_SRF = 2, P_WR = 1, P_WRA = 0;

   typedef struct {
      logic [18:0] vec;
      int          pwr;
      int          err;
   } exp_t;

   logic clk;
   logic rst;
   ddr_cmd_decoder_if bus ();

   ddr_cmd_decoder dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [18:0] dut_vec;
   assign dut_vec = {bus.ACT, bus.BST, bus.CFG, bus.CKEH, bus.CKEL, bus.DPD,
                     bus.DPDX, bus.MRR, bus.MRW, bus.PD, bus.PDX, bus.PR,
                     bus.PRA, bus.RD, bus.RDA, bus.REF, bus.SRF, bus.WR, bus.WRA};

   int    checks = 0;
   int    errors = 0;
   exp_t  sb_q[$];
   exp_t  mon_e;
   string m_mode;
   int    m_err;
   bit    m_prev;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
      end
   endtask

   function automatic string cmd_name(input bit cs, input bit an, input bit [2:0] rcw);
      if (cs) return "DES";
      if (!an) return "ACT";
      case (rcw)
         3'd0: return "MRS";
         3'd1: return "REF";
         3'd2: return "PRE";
         3'd3: return "BST";
         3'd4: return "WR";
         3'd5: return "RD";
         3'd6: return "RSV";
         default: return "NOP";
      endcase
   endfunction

   function automatic int mode_code(input string m);
      if (m == "PDN") return 1;
      if (m == "SREF") return 2;
      if (m == "DPDN") return 3;
      return 0;
   endfunction

   function automatic void bump();
      if (m_err < 255) m_err = m_err + 1;
   endfunction

   // Reference: what this edge should produce, straight from the command rules
   task automatic model_step();
      exp_t  e;
      string c;
      bit    fell, rose, k;
      e.vec = '0;
      if (rst) begin
         m_mode = "ACTIVE";
         m_err  = 0;
         m_prev = 1'b1;
      end else begin
         k    = bus.cke;
         c    = cmd_name(bus.cs_n, bus.act_n, {bus.ras_n, bus.cas_n, bus.we_n});
         fell = m_prev && !k;
         rose = !m_prev && k;
         if (m_mode == "ACTIVE") begin
            if (fell) begin
               e.vec[P_CKEL] = 1'b1;
               if (c == "REF") begin e.vec[P_SRF] = 1'b1; m_mode = "SREF"; end
               else if (c == "BST") begin e.vec[P_DPD] = 1'b1; m_mode = "DPDN"; end
               else begin
                  e.vec[P_PD] = 1'b1;
                  m_mode = "PDN";
                  if (c != "NOP" && c != "DES") bump();
               end
            end else if (rose) begin
               e.vec[P_CKEH] = 1'b1;
            end else if (k) begin
               if (c == "ACT") e.vec[P_ACT] = 1'b1;
               if (c == "MRS") begin
                  if (bus.a13) e.vec[P_MRR] = 1'b1;
                  else begin e.vec[P_MRW] = 1'b1; e.vec[P_CFG] = bus.a12; end
               end
               if (c == "REF") e.vec[P_REF] = 1'b1;
               if (c == "PRE") e.vec[bus.a10 ? P_PRA : P_PR] = 1'b1;
               if (c == "BST") e.vec[P_BST] = 1'b1;
               if (c == "WR")  e.vec[bus.a10 ? P_WRA : P_WR] = 1'b1;
               if (c == "RD")  e.vec[bus.a10 ? P_RDA : P_RD] = 1'b1;
               if (c == "RSV") bump();
            end
         end else begin
            if (rose) begin
               e.vec[P_CKEH] = 1'b1;
               if (m_mode == "PDN")  e.vec[P_PDX] = 1'b1;
               if (m_mode == "DPDN") e.vec[P_DPDX] = 1'b1;
               m_mode = "ACTIVE";
            end else if (fell) begin
               bump();
            end else if (!k && c != "NOP" && c != "DES") begin
               bump();
            end
         end
         m_prev = k;
      end
      e.pwr = mode_code(m_mode);
      e.err = m_err;
      sb_q.push_back(e);
   endtask

   // One clock: drive pins on the falling edge, predict at the rising edge
   task automatic step(input bit r, input bit k, input bit cs, input bit an,
                       input bit [2:0] rcw, input bit a10v, input bit a12v, input bit a13v);
      @(negedge clk);
      rst       = r;
      bus.cke   = k;
      bus.cs_n  = cs;
      bus.act_n = an;
      bus.ras_n = rcw[2];
      bus.cas_n = rcw[1];
      bus.we_n  = rcw[0];
      bus.a10   = a10v;
      bus.a12   = a12v;
      bus.a13   = a13v;
      @(posedge clk);
      model_step();
   endtask

   task automatic idle(input bit k);
      step(1'b0, k, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic cmd(input bit k, input bit [2:0] rcw, input bit a10v, input bit a12v, input bit a13v);
      step(1'b0, k, 1'b0, 1'b1, rcw, a10v, a12v, a13v);
   endtask

   task automatic do_reset(input bit k);
      step(1'b1, k, 1'b0, 1'b1, 3'b101, 1'b0, 1'b0, 1'b0);
   endtask

   // Monitor: outputs are registered, so compare one per falling edge
   always @(negedge clk) begin
      if (sb_q.size() != 0) begin
         mon_e = sb_q.pop_front();
         check("pulses",    32'(dut_vec),       32'(mon_e.vec));
         check("pwr_state", 32'(bus.pwr_state), mon_e.pwr);
         check("err_ct",    32'(bus.err_ct),    mon_e.err);
      end
   end

   initial begin
      bit kc;
      rst = 1'b1; bus.cke = 1'b1; bus.cs_n = 1'b1; bus.act_n = 1'b1;
      bus.ras_n = 1'b1; bus.cas_n = 1'b1; bus.we_n = 1'b1;
      bus.a10 = 1'b0; bus.a12 = 1'b0; bus.a13 = 1'b0;
      m_mode = "ACTIVE"; m_err = 0; m_prev = 1'b1;

      // Reset with cke low and a command on the pins: all ignored
      repeat (3) do_reset(1'b0);
      idle(1'b1);
      #1;
      check("reset_pwr", 32'(bus.pwr_state), 32'd0);
      check("reset_ckeh", 32'(bus.CKEH), 32'd0);

      // ACT, then its one-cycle width
      step(1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0);
      #1; check("act_pulse", 32'(bus.ACT), 32'd1);
      idle(1'b1);
      #1; check("act_width", 32'(bus.ACT), 32'd0);

      // Full command table
      cmd(1'b1, 3'b101, 1'b1, 1'b0, 1'b0);
      cmd(1'b1, 3'b101, 1'b0, 1'b0, 1'b0);
      cmd(1'b1, 3'b100, 1'b1, 1'b0, 1'b0);
      cmd(1'b1, 3'b100, 1'b0, 1'b0, 1'b0);
      cmd(1'b1, 3'b010, 1'b1, 1'b0, 1'b0);
      cmd(1'b1, 3'b010, 1'b0, 1'b0, 1'b0);
      cmd(1'b1, 3'b000, 1'b0, 1'b0, 1'b1);
      cmd(1'b1, 3'b000, 1'b0, 1'b1, 1'b0);
      cmd(1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
      cmd(1'b1, 3'b001, 1'b0, 1'b0, 1'b0);
      cmd(1'b1, 3'b011, 1'b0, 1'b0, 1'b0);
      cmd(1'b1, 3'b110, 1'b0, 1'b0, 1'b0);
      cmd(1'b1, 3'b111, 1'b0, 1'b0, 1'b0);
      idle(1'b1);

      // Self refresh entry and exit
      cmd(1'b0, 3'b001, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b1);
      idle(1'b1);

      // Power-down with an ignored RD, then exit with PDX
      do_reset(1'b1);
      cmd(1'b0, 3'b111, 1'b0, 1'b0, 1'b0);
      cmd(1'b0, 3'b101, 1'b0, 1'b0, 1'b0);
      #1; check("pdn_rd_err", 32'(bus.err_ct), 32'd1);
      idle(1'b1);
      idle(1'b1);

      // Illegal command on power-down entry, RD on the exit edge
      cmd(1'b0, 3'b100, 1'b1, 1'b0, 1'b0);
      cmd(1'b1, 3'b101, 1'b0, 1'b0, 1'b0);
      idle(1'b1);

      // Deep power-down cut short by reset: no DPDX/CKEH
      cmd(1'b0, 3'b011, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
      do_reset(1'b1);
      idle(1'b1);
      #1; check("dpdn_rst_dpdx", 32'(bus.DPDX), 32'd0);

      // cke low on the first edge after reset is a falling edge
      do_reset(1'b1);
      idle(1'b0);
      idle(1'b1);

      // Error counter saturation
      do_reset(1'b1);
      repeat (300) cmd(1'b1, 3'b110, 1'b0, 1'b0, 1'b0);
      #1; check("err_sat", 32'(bus.err_ct), 32'd255);
      cmd(1'b1, 3'b110, 1'b0, 1'b0, 1'b0);
      #1; check("err_hold", 32'(bus.err_ct), 32'd255);
      do_reset(1'b1);

      // Random pins, cke mostly steady, occasional reset
      kc = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) == 0) kc = ~kc;
         step(bit'($urandom_range(0, 149) == 0), kc,
              bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0),
              3'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
              bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      end
      idle(1'b1);

      // Drain the scoreboard within a bounded number of cycles
      for (int i = 0; i < 4 && sb_q.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ddr_cmd_decoder.md
DDR_CMD_DECODER -- requirements
Module: ddr_cmd_decoder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with these ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 The command pin inputs SHALL be: cke, cs_n, act_n, ras_n, cas_n, we_n  in  1 each  DRAM command pins, sampled on clk.
REQ-003 The address inputs SHALL be: a10  in  1  auto-precharge / all-bank select; a12  in  1  config-write select; a13  in  1  mode-register read select.
REQ-004 The outputs ACT, BST, CFG, CKEH, CKEL, DPD, DPDX, MRR, MRW, PD, PDX, PR, PRA, RD, RDA, REF, SRF, WR, WRA SHALL each be  out  1  one-cycle decoded pulses for the timing FSM.
REQ-005 The output pwr_state SHALL be  out  2  current power mode: 0 ACTIVE, 1 PDN, 2 SREF, 3 DPDN.
REQ-006 The output err_ct SHALL be  out  8  saturating count of illegal or ignored commands.

Function
REQ-007 All pulse outputs SHALL be registered: pins sampled at edge n produce the pulse during cycle n+1, high for exactly one cycle.
REQ-008 The block SHALL hold cke_q, the previous sampled cke; a cke edge is cke_q!=cke.
REQ-009 In ACTIVE with cke_q=1, cke=1, cs_n=0 and act_n=0, the block SHALL pulse ACT.
REQ-010 In ACTIVE with cke_q=1, cke=1, cs_n=0 and act_n=1, the block SHALL decode ras_n/cas_n/we_n as follows:
- 000 MRS: a13=1 gives MRR; a13=0 gives MRW, plus CFG if a12=1.
- 001 gives REF.
- 010 gives PR if a10=0, PRA if a10=1.
- 011 gives BST.
- 100 gives WR or WRA (a10).
- 101 gives RD or RDA (a10).
- 110 is reserved: no pulse, err_ct+1.
- 111 is NOP: no pulse.
REQ-011 cs_n=1 (deselect) SHALL produce no command pulse.
REQ-012 Apart from the cke pairings below, at most one command pulse SHALL be high per cycle.
REQ-013 A cke falling edge in ACTIVE SHALL pulse CKEL and select the mode from the same-cycle command:
- REF encoding gives SRF and moves to SREF.
- BST encoding gives DPD and moves to DPDN.
- NOP or deselect gives PD and moves to PDN.
- Any other command gives PD, moves to PDN, suppresses that command and adds 1 to err_ct.
REQ-014 A cke rising edge SHALL pulse CKEH and return to ACTIVE, additionally pulsing PDX from PDN and DPDX from DPDN; from SREF, CKEH is the only pulse.
REQ-015 In PDN, SREF or DPDN, commands SHALL be ignored; cs_n=0 with a non-NOP encoding while cke=0 SHALL add 1 to err_ct.
REQ-016 A cke rising edge while in ACTIVE (a glitch) SHALL pulse CKEH only, with no state change.
REQ-017 A cke falling edge in a low-power state SHALL be impossible; if it occurs, the block SHALL pulse no output and add 1 to err_ct.
REQ-018 err_ct SHALL saturate at 8'd255 and never wrap.
REQ-019 pwr_state SHALL update on the same edge as the pulse that announces the transition.

Reset
REQ-020 When rst=1 at a clock edge, the block SHALL apply the following on that edge:
- all pulse outputs 0;
- pwr_state ACTIVE;
- err_ct 0;
- cke_q 1, so that cke high after reset produces no CKEH.
REQ-021 The block SHALL ignore pins sampled while rst=1, including a cke low during reset.
REQ-022 On the first edge after rst deasserts, a sampled cke=0 SHALL be treated as a falling edge (REQ-013).
REQ-023 A rst asserted in mid power-down SHALL return the block to ACTIVE without a PDX or DPDX pulse.

Structure
REQ-024 The shared package ddr_cmd_pkg SHALL hold:
- the ras/cas/we encoding constants;
- the power-mode enumeration;
- the err_ct width (8).
REQ-025 A combinational sub-module ddr_cmd_table SHALL map pins plus a10/a12/a13 to a one-hot command vector.
REQ-026 The power-mode FSM, the edge logic and the output registers SHALL reside in ddr_cmd_decoder.

Verification
REQ-027 Scenario 1: cs_n=0, act_n=0, cke=1 at edge 5 -> ACT=1 during cycle 6 only; all other outputs 0.
REQ-028 Scenario 2: ras/cas/we=101 with a10=1 -> RDA pulse; with a10=0 -> RD pulse; 100 with a10=1 -> WRA; 010 with a10=1 -> PRA.
REQ-029 Scenario 3: REF encoding with cke 1->0 -> CKEL and SRF in the same cycle, pwr_state=2; cke 0->1 -> CKEH only, pwr_state=0.
REQ-030 Scenario 4: NOP with cke 1->0 -> CKEL and PD, pwr_state=1; then RD issued with cke=0 -> no RD, err_ct=1; cke 0->1 -> CKEH and PDX, pwr_state=0.
REQ-031 Scenario 5: BST encoding with cke falling -> DPD and CKEL, pwr_state=3; rst pulsed for 1 cycle -> pwr_state=0, err_ct=0, no DPDX or CKEH.
REQ-032 Scenario 6: 300 cycles of the reserved encoding 110 -> err_ct reaches 255 and stays at 255.
